// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result bundle for the sequential magnitude comparator.
// master drives start/operands, slave (the comparator) returns busy/done/result.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             AiB;
    logic             AsB;
    logic             AeB;
    logic [CW-1:0]    cmp_cycles;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, AiB, AsB, AeB, cmp_cycles
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, AiB, AsB, AeB, cmp_cycles
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// MSB-first slice-serial magnitude compare (unsigned or two's complement), early exit on mismatch.
// Latency: 1..NDIG edges from accept to done (index of first differing slice, NDIG if equal).
// Backpressure: start is accepted only while busy=0; start during busy is dropped, never queued.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic clk,
    input  logic rst,
    seq_magnitude_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic             sgn_cap;
    logic [IW-1:0]    idx;
    logic             done_q, aib_q, asb_q, aeb_q;
    logic [CW-1:0]    cyc_q;

    logic [DIGIT-1:0] a_sl [NDIG];
    logic [DIGIT-1:0] b_sl [NDIG];
    logic [DIGIT-1:0] a_cur, b_cur;
    logic             accept, last, gt, lt;

    for (genvar g = 0; g < NDIG; g++) begin : g_slice
        assign a_sl[g] = a_cap[WIDTH-1-g*DIGIT -: DIGIT];
        assign b_sl[g] = b_cap[WIDTH-1-g*DIGIT -: DIGIT];
    end

    // Sign-flip on the top slice turns two's-complement order into plain unsigned order.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int g = 0; g < NDIG; g++) begin
            if (idx == IW'(g)) begin
                a_cur = a_sl[g];
                b_cur = b_sl[g];
            end
        end
        if (sgn_cap && idx == '0) begin
            a_cur = a_cur ^ MSB_MASK;
            b_cur = b_cur ^ MSB_MASK;
        end
    end

    assign accept = (state == IDLE) && bus.start;
    assign last   = (idx == IW'(NDIG - 1));
    assign gt     = (a_cur > b_cur);
    assign lt     = (a_cur < b_cur);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)        state_nxt = SCAN;
            SCAN:    if (gt || lt || last) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SCAN);
    end

    // Operand copies only load on accept so they stay quiet while idle.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            a_cap   <= bus.A;
            b_cap   <= bus.B;
            sgn_cap <= bus.signed_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            done_q <= 1'b0;
            aib_q  <= 1'b0;
            asb_q  <= 1'b0;
            aeb_q  <= 1'b0;
            cyc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                idx   <= '0;
                aib_q <= 1'b0;
                asb_q <= 1'b0;
                aeb_q <= 1'b0;
            end else if (state == SCAN) begin
                if (gt || lt) begin
                    aib_q  <= gt;
                    asb_q  <= lt;
                    cyc_q  <= CW'(idx) + CW'(1);
                    done_q <= 1'b1;
                end else if (last) begin
                    aeb_q  <= 1'b1;
                    cyc_q  <= CW'(NDIG);
                    done_q <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    assign bus.done       = done_q;
    assign bus.AiB        = aib_q;
    assign bus.AsB        = asb_q;
    assign bus.AeB        = aeb_q;
    assign bus.cmp_cycles = cyc_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: main 16/4 instance plus degenerate 8/8 and 8/1 instances.
// Vector table, hand-written handshake/reset sequences and random compares against an arithmetic model.
module tb_seq_magnitude_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_magnitude_comparator_if #(.WIDTH(16), .DIGIT(4)) m_if ();
    seq_magnitude_comparator_if #(.WIDTH(8),  .DIGIT(8)) w_if ();
    seq_magnitude_comparator_if #(.WIDTH(8),  .DIGIT(1)) n_if ();

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut_m (.clk(clk), .rst(rst), .bus(m_if.slave));
    seq_magnitude_comparator #(.WIDTH(8),  .DIGIT(8)) dut_w (.clk(clk), .rst(rst), .bus(w_if.slave));
    seq_magnitude_comparator #(.WIDTH(8),  .DIGIT(1)) dut_n (.clk(clk), .rst(rst), .bus(n_if.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        bit          s;
        int          gt;
        int          lt;
        int          eq;
        int          k;
    } vec_t;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(int sel, bit st, bit s, logic [15:0] a, logic [15:0] b);
        case (sel)
            0: begin m_if.start = st; m_if.signed_mode = s; m_if.A = a;      m_if.B = b;      end
            1: begin w_if.start = st; w_if.signed_mode = s; w_if.A = a[7:0]; w_if.B = b[7:0]; end
            default: begin n_if.start = st; n_if.signed_mode = s; n_if.A = a[7:0]; n_if.B = b[7:0]; end
        endcase
    endtask

    task automatic set_start(int sel, bit st);
        case (sel)
            0: m_if.start = st;
            1: w_if.start = st;
            default: n_if.start = st;
        endcase
    endtask

    // {busy, done, AiB, AsB, AeB} packed for compact checking
    function automatic logic [4:0] flags(int sel);
        case (sel)
            0: return {m_if.busy, m_if.done, m_if.AiB, m_if.AsB, m_if.AeB};
            1: return {w_if.busy, w_if.done, w_if.AiB, w_if.AsB, w_if.AeB};
            default: return {n_if.busy, n_if.done, n_if.AiB, n_if.AsB, n_if.AeB};
        endcase
    endfunction

    function automatic int cyc(int sel);
        case (sel)
            0: return int'(m_if.cmp_cycles);
            1: return int'(w_if.cmp_cycles);
            default: return int'(n_if.cmp_cycles);
        endcase
    endfunction

    function automatic int sel_w(int sel);
        return (sel == 0) ? 16 : 8;
    endfunction

    function automatic int sel_d(int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 8 : 1;
    endfunction

    // Order from integer arithmetic, latency from the highest differing bit position.
    task automatic model(int w, int d, logic [15:0] a, logic [15:0] b, bit s,
                         output int gt, output int lt, output int eq, output int k);
        longint av, bv, mask, x;
        int p;
        mask = (64'sd1 <<< w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (s && av[w-1]) av = av - (64'sd1 <<< w);
        if (s && bv[w-1]) bv = bv - (64'sd1 <<< w);
        gt = int'(av > bv);
        lt = int'(av < bv);
        eq = int'(av == bv);
        x = (longint'(a ^ b)) & mask;
        if (x == 0) k = w / d;
        else begin
            p = 0;
            for (int i = 0; i < w; i++) if (x[i]) p = i;
            k = (w - 1 - p) / d + 1;
        end
    endtask

    // Accept at the next edge, then count edges until done; sampling on negedges.
    task automatic wait_done(int sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!flags(sel)[3] && n < 40);
    endtask

    task automatic run(int sel, logic [15:0] a, logic [15:0] b, bit s,
                       int egt, int elt, int eeq, int ek, string tag);
        int n;
        @(negedge clk);
        set_in(sel, 1'b1, s, a, b);
        @(negedge clk);
        set_in(sel, 1'b0, s, ~a, ~b);
        chk({tag, " busy/flags after accept"}, int'(flags(sel)), 5'b10000);
        wait_done(sel, n);
        chk({tag, " latency"}, n, ek);
        chk({tag, " {done,AiB,AsB,AeB}"}, int'(flags(sel)),
            int'({1'b0, 1'b1, egt[0], elt[0], eeq[0]}));
        chk({tag, " cmp_cycles"}, cyc(sel), ek);
        @(negedge clk);
        chk({tag, " done pulse one cycle"}, int'(flags(sel)[3]), 0);
    endtask

    vec_t vt[$];

    initial begin
        int n, gt, lt, eq, k;
        logic [15:0] ra, rb;
        bit rs;
        int sel;

        set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_in(1, 1'b0, 1'b0, 16'h0, 16'h0);
        set_in(2, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset flags main", int'(flags(0)), 0);
        chk("reset cmp_cycles main", cyc(0), 0);
        chk("reset flags 8x1", int'(flags(2)), 0);

        vt.push_back('{0, 16'h1234, 16'h1234, 1'b0, 0, 0, 1, 4});
        vt.push_back('{0, 16'h9000, 16'h1FFF, 1'b0, 1, 0, 0, 1});
        vt.push_back('{0, 16'h9000, 16'h1FFF, 1'b1, 0, 1, 0, 1});
        vt.push_back('{0, 16'hFFFF, 16'hFFFE, 1'b1, 1, 0, 0, 4});
        vt.push_back('{0, 16'h1235, 16'h1234, 1'b0, 1, 0, 0, 4});
        vt.push_back('{0, 16'h0001, 16'h0002, 1'b0, 0, 1, 0, 4});
        vt.push_back('{0, 16'h8000, 16'h7FFF, 1'b1, 0, 1, 0, 1});
        vt.push_back('{0, 16'h8000, 16'h7FFF, 1'b0, 1, 0, 0, 1});
        vt.push_back('{0, 16'h1200, 16'h1300, 1'b0, 0, 1, 0, 2});
        vt.push_back('{0, 16'hAB70, 16'hAB6F, 1'b1, 1, 0, 0, 3});
        vt.push_back('{0, 16'h0000, 16'h0000, 1'b1, 0, 0, 1, 4});
        vt.push_back('{1, 16'h0012, 16'h0034, 1'b0, 0, 1, 0, 1});
        vt.push_back('{1, 16'h0080, 16'h0001, 1'b1, 0, 1, 0, 1});
        vt.push_back('{1, 16'h0055, 16'h0055, 1'b0, 0, 0, 1, 1});
        vt.push_back('{2, 16'h0001, 16'h0000, 1'b0, 1, 0, 0, 8});
        vt.push_back('{2, 16'h0080, 16'h0000, 1'b1, 0, 1, 0, 1});
        vt.push_back('{2, 16'h00C4, 16'h00C4, 1'b1, 0, 0, 1, 8});
        foreach (vt[i])
            run(vt[i].sel, vt[i].a, vt[i].b, vt[i].s,
                vt[i].gt, vt[i].lt, vt[i].eq, vt[i].k, $sformatf("vec%0d", i));

        // busy-ignore then back-to-back start held during the done cycle
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h1235, 16'h1234);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 16'h1235, 16'h1234);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h0000, 16'h1234);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 16'h0000, 16'h1234);
        n = 2;
        while (!flags(0)[3] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first latency", n, 4);
        chk("b2b first flags", int'(flags(0)), 5'b01100);
        chk("b2b first cmp_cycles", cyc(0), 4);
        set_in(0, 1'b1, 1'b0, 16'h0001, 16'h0002);
        @(negedge clk);
        set_start(0, 1'b0);
        chk("b2b accept clears flags", int'(flags(0)), 5'b10000);
        wait_done(0, n);
        chk("b2b second latency", n, 4);
        chk("b2b second flags", int'(flags(0)), 5'b01010);

        // reset on the 2nd scan edge of an equal compare
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h1234, 16'h1234);
        @(negedge clk);
        set_start(0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midscan reset flags", int'(flags(0)), 0);
        chk("midscan reset cmp_cycles", cyc(0), 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (flags(0)[3]) n++;
        end
        chk("midscan no done", n, 0);

        for (int i = 0; i < 240; i++) begin
            sel = i % 3;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? (ra ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
            if ($urandom_range(0, 9) == 0) rb = ra;
            if (sel != 0) begin ra[15:8] = 8'h0; rb[15:8] = 8'h0; end
            rs = bit'($urandom_range(0, 1));
            model(sel_w(sel), sel_d(sel), ra, rb, rs, gt, lt, eq, k);
            run(sel, ra, rb, rs, gt, lt, eq, k, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
